video_pos_scheduler: RTL and testbench

//  Frame-level sequencer for the Hpos/Vpos position generator. It drives the generator's

---
 rtl/video_pkg.sv | 16 +
 rtl/pos_skid_buf.sv | 58 +++++
 rtl/video_pos_scheduler.sv | 128 ++++++++++++
 tb/tb_video_pos_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants and the frame-scheduler state encoding.
// The default raster size is also used by the display pipeline.
package video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int cDefHeight = 480;
    localparam int cDefWidth  = 640;

endpackage

// File: rtl/pos_skid_buf.sv
// Two-entry valid/ready skid buffer. Entry 0 is the head and drives the
// registered outputs, so there is no combinational iReady->oValid path.
module pos_skid_buf #(
    parameter int pPayloadW = 8
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iPush,
    input  logic [pPayloadW-1:0] iData,
    output logic                 oFull,
    output logic                 oValid,
    output logic [pPayloadW-1:0] oData,
    input  logic                 iReady
);

    logic [1:0]           count;
    logic [pPayloadW-1:0] ent0;
    logic [pPayloadW-1:0] ent1;
    logic                 push;
    logic                 pop;

    assign pop    = (count != 2'd0) && iReady;
    assign push   = iPush && (count != 2'd2);
    assign oFull  = (count == 2'd2);
    assign oValid = (count != 2'd0);
    assign oData  = ent0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= iData;
                    else               ent1 <= iData;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        ent0 <= iData;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= iData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/video_pos_scheduler.sv
// Frame-level sequencer for the Hpos/Vpos generator: paces oCKE into a skid
// buffer and presents (x,y) with SOF/EOL as a valid/ready stream.
module video_pos_scheduler
    import video_pkg::*;
#(
    parameter int pHeight      = cDefHeight,
    parameter int pWidth       = cDefWidth,
    parameter int pBitHeight   = 10,
    parameter int pBitWidth    = 10,
    parameter int pFrameCntBit = 16
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iEnable,
    input  logic                    iOneShot,
    input  logic                    iVsync,
    input  logic                    iClrErr,
    output logic                    oCKE,
    input  logic [pBitWidth-1:0]    iDwp,
    input  logic [pBitHeight-1:0]   iDhp,
    input  logic                    iFe,
    output logic [pBitWidth-1:0]    oPixX,
    output logic [pBitHeight-1:0]   oPixY,
    output logic                    oSof,
    output logic                    oEol,
    output logic                    oValid,
    input  logic                    iReady,
    output logic                    oBusy,
    output logic                    oFrameDone,
    output logic [pFrameCntBit-1:0] oFrameCnt,
    output logic                    oSyncMiss
);

    localparam int cPayW = pBitWidth + pBitHeight + 2;
    localparam logic [pBitWidth-1:0]  cLastX = pBitWidth'(pWidth - 1);
    localparam logic [pBitHeight-1:0] cLastY = pBitHeight'(pHeight - 1);

    sched_state_t     state;
    logic             enPrev;
    logic             enRise;
    logic             lastIssued;
    logic             feSeen;
    logic             bufFull;
    logic             atLastX;
    logic             lastPix;
    logic             isSof;
    logic [cPayW-1:0] bufData;

    assign atLastX = (iDwp == cLastX);
    assign lastPix = atLastX && (iDhp == cLastY);
    assign isSof   = (iDwp == '0) && (iDhp == '0);
    assign enRise  = iEnable && !enPrev;

    // The last-issued flag keeps a frame at exactly pWidth*pHeight slots.
    assign oCKE  = (state == RUN) && !bufFull && !lastIssued;
    assign oBusy = (state != IDLE);

    pos_skid_buf #(
        .pPayloadW(cPayW)
    ) uSkid (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iPush (oCKE),
        .iData ({iDwp, iDhp, isSof, atLastX}),
        .oFull (bufFull),
        .oValid(oValid),
        .oData (bufData),
        .iReady(iReady)
    );

    assign {oPixX, oPixY, oSof, oEol} = bufData;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            enPrev     <= 1'b0;
            lastIssued <= 1'b0;
            feSeen     <= 1'b0;
            oFrameDone <= 1'b0;
            oFrameCnt  <= '0;
            oSyncMiss  <= 1'b0;
        end else begin
            enPrev     <= iEnable;
            oFrameDone <= 1'b0;

            if (iClrErr)
                oSyncMiss <= 1'b0;
            else if (iVsync && (state != WAIT))
                oSyncMiss <= 1'b1;

            if (iFe) feSeen <= 1'b1;

            case (state)
                IDLE: begin
                    if (iEnable && (!iOneShot || enRise)) state <= WAIT;
                end
                WAIT: begin
                    if (!iEnable) begin
                        state <= IDLE;
                    end else if (iVsync) begin
                        state      <= RUN;
                        lastIssued <= 1'b0;
                        feSeen     <= 1'b0;
                    end
                end
                RUN: begin
                    if (oCKE && lastPix) begin
                        lastIssued <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A generator that never pulses iFe parks the sequencer here.
                    if (feSeen && !oValid) begin
                        state      <= DONE;
                        oFrameDone <= 1'b1;
                        oFrameCnt  <= oFrameCnt + pFrameCntBit'(1);
                    end
                end
                DONE: begin
                    state <= (iEnable && !iOneShot) ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_pos_scheduler.sv
// Scoreboard bench for video_pos_scheduler on a 4x3 raster with a bench-side
// Hpos/Vpos generator; stimulus pushes expected beats, a monitor pops and compares.
module tb_video_pos_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BW = 10;
    localparam int BH = 10;
    localparam int FB = 16;

    typedef struct packed {
        logic [BW-1:0] x;
        logic [BH-1:0] y;
        logic          sof;
        logic          eol;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          oneShot = 1'b0;
    logic          vsync = 1'b0;
    logic          clrErr = 1'b0;
    logic          ready = 1'b1;
    logic          cke;
    logic [BW-1:0] genX;
    logic [BH-1:0] genY;
    logic          genFe;
    logic [BW-1:0] pixX;
    logic [BH-1:0] pixY;
    logic          sof;
    logic          eol;
    logic          valid;
    logic          busy;
    logic          frameDone;
    logic [FB-1:0] frameCnt;
    logic          syncMiss;

    beat_t expQ[$];
    int    doneQ[$];
    int    tests = 0;
    int    fails = 0;
    int    beatsSeen = 0;
    int    donesSeen = 0;
    int    occ = 0;
    int    readyMode = 0;

    always #5 clk = ~clk;

    video_pos_scheduler #(
        .pHeight(H), .pWidth(W), .pBitHeight(BH), .pBitWidth(BW), .pFrameCntBit(FB)
    ) dut (
        .iCLK(clk), .iRST(rst), .iEnable(en), .iOneShot(oneShot), .iVsync(vsync),
        .iClrErr(clrErr), .oCKE(cke), .iDwp(genX), .iDhp(genY), .iFe(genFe),
        .oPixX(pixX), .oPixY(pixY), .oSof(sof), .oEol(eol), .oValid(valid),
        .iReady(ready), .oBusy(busy), .oFrameDone(frameDone), .oFrameCnt(frameCnt),
        .oSyncMiss(syncMiss)
    );

    // Raster position generator sharing the DUT reset.
    always @(posedge clk) begin
        if (rst) begin
            genX  <= '0;
            genY  <= '0;
            genFe <= 1'b0;
        end else begin
            genFe <= 1'b0;
            if (cke) begin
                if (genX == BW'(W - 1)) begin
                    genX <= '0;
                    if (genY == BH'(H - 1)) begin
                        genY  <= '0;
                        genFe <= 1'b1;
                    end else begin
                        genY <= genY + BH'(1);
                    end
                end else begin
                    genX <= genX + BW'(1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) occ <= 0;
        else     occ <= occ + (cke ? 1 : 0) - ((valid && ready) ? 1 : 0);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst) begin
            if (cke) check("cke_while_full", int'(occ == 2), 0);
            check("valid_vs_occupancy", int'(valid), int'(occ != 0));
            if (valid && ready) begin
                beatsSeen++;
                check("beat_expected", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    check("beat_x", int'(pixX), int'(e.x));
                    check("beat_y", int'(pixY), int'(e.y));
                    check("beat_sof", int'(sof), int'(e.sof));
                    check("beat_eol", int'(eol), int'(e.eol));
                end
            end
            if (frameDone) begin
                donesSeen++;
                check("done_expected", int'(doneQ.size() != 0), 1);
                if (doneQ.size() != 0) begin
                    check("frame_cnt", int'(frameCnt), doneQ.pop_front());
                    check("drained_at_done", expQ.size(), 0);
                end
            end
        end
    end

    initial begin : readyDriver
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: ready = 1'b1;
                1: begin
                    ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: ready = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseVsync();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
    endtask

    task automatic startFrame(input int expCnt);
        beat_t b;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                b.x   = BW'(x);
                b.y   = BH'(y);
                b.sof = (x == 0) && (y == 0);
                b.eol = (x == W - 1);
                expQ.push_back(b);
            end
        end
        doneQ.push_back(expCnt);
        pulseVsync();
    endtask

    task automatic doReset();
        rst = 1'b1;
        expQ.delete();
        doneQ.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic waitBeats(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (beatsSeen < target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(beatsSeen >= target), 1);
    endtask

    task automatic waitDone(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (donesSeen < target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(donesSeen >= target), 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int base;
        int dbase;

        // Reset state
        tick(3);
        check("rst_valid", int'(valid), 0);
        check("rst_cke", int'(cke), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_framecnt", int'(frameCnt), 0);
        check("rst_syncmiss", int'(syncMiss), 0);
        check("rst_framedone", int'(frameDone), 0);
        rst = 1'b0;

        // 1: free-run, vsync every 20 clocks
        en = 1'b1;
        tick(3);
        base = beatsSeen;
        for (int f = 1; f <= 3; f++) begin
            startFrame(f);
            tick(19);
        end
        waitDone(3, 60, "t1_done_timeout");
        check("t1_beats", beatsSeen - base, 36);
        check("t1_framecnt", int'(frameCnt), 3);
        check("t1_syncmiss", int'(syncMiss), 0);

        // 2: backpressure 1 on / 2 off
        doReset();
        readyMode = 1;
        tick(3);
        base  = beatsSeen;
        dbase = donesSeen;
        startFrame(1);
        waitDone(dbase + 1, 300, "t2_done_timeout");
        readyMode = 0;
        check("t2_beats", beatsSeen - base, 12);

        // 3: one-shot
        en = 1'b0;
        doReset();
        oneShot = 1'b1;
        tick(2);
        en = 1'b1;
        tick(3);
        base  = beatsSeen;
        dbase = donesSeen;
        startFrame(1);
        tick(19);
        pulseVsync();
        tick(19);
        pulseVsync();
        tick(19);
        check("t3_busy", int'(busy), 0);
        check("t3_framecnt", int'(frameCnt), 1);
        check("t3_beats", beatsSeen - base, 12);
        check("t3_dones", donesSeen - dbase, 1);
        oneShot = 1'b0;

        // 4: stop request mid-frame
        doReset();
        tick(3);
        base  = beatsSeen;
        dbase = donesSeen;
        startFrame(1);
        waitBeats(base + 5, 60, "t4_beat5_timeout");
        en = 1'b0;
        waitDone(dbase + 1, 100, "t4_done_timeout");
        tick(3);
        check("t4_busy_after", int'(busy), 0);
        check("t4_beats", beatsSeen - base, 12);
        pulseVsync();
        tick(30);
        check("t4_busy_late", int'(busy), 0);
        check("t4_beats_late", beatsSeen - base, 12);
        check("t4_dones_late", donesSeen - dbase, 1);

        // 5: sync miss during RUN
        en = 1'b1;
        doReset();
        tick(3);
        base  = beatsSeen;
        dbase = donesSeen;
        startFrame(1);
        waitBeats(base + 3, 60, "t5_beat3_timeout");
        check("t5_syncmiss_before", int'(syncMiss), 0);
        pulseVsync();
        tick(1);
        check("t5_syncmiss_set", int'(syncMiss), 1);
        waitDone(dbase + 1, 100, "t5_done_timeout");
        tick(2);
        check("t5_syncmiss_sticky", int'(syncMiss), 1);
        clrErr = 1'b1;
        tick(1);
        clrErr = 1'b0;
        check("t5_syncmiss_cleared", int'(syncMiss), 0);
        check("t5_beats", beatsSeen - base, 12);

        // 6: reset mid-frame under backpressure
        doReset();
        tick(3);
        base = beatsSeen;
        startFrame(1);
        waitBeats(base + 7, 60, "t6_beat7_timeout");
        readyMode = 2;
        tick(4);
        check("t6_valid_held", int'(valid), 1);
        rst = 1'b1;
        expQ.delete();
        doneQ.delete();
        tick(1);
        rst = 1'b0;
        check("t6_valid", int'(valid), 0);
        check("t6_cke", int'(cke), 0);
        check("t6_framecnt", int'(frameCnt), 0);
        check("t6_busy", int'(busy), 0);
        readyMode = 0;
        tick(3);
        base  = beatsSeen;
        dbase = donesSeen;
        startFrame(1);
        waitDone(dbase + 1, 100, "t6_done_timeout");
        check("t6_beats", beatsSeen - base, 12);

        tick(5);
        check("final_beat_queue", expQ.size(), 0);
        check("final_done_queue", doneQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
